// File: rtl/memory_pkg.sv
// Shared encodings for the cache-to-memory arbiter: FSM states, port indices,
// memory operation codes and the two-way round-robin pick function.
package memory_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;
  localparam logic [1:0] ST_FLUSH = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StIssue = ST_ISSUE,
    StDone  = ST_DONE,
    StFlush = ST_FLUSH
  } state_e;

  localparam logic PORT_ICACHE = 1'b0;
  localparam logic PORT_DCACHE = 1'b1;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // A lone requester wins; on a tie the port not served last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
    if (req[PORT_ICACHE] && req[PORT_DCACHE]) begin
      return ~last_grant;
    end
    return req[PORT_DCACHE] ? PORT_DCACHE : PORT_ICACHE;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr.sv
// Two-requester round-robin grant logic; last_grant is only advanced when the
// owner of the memory port signals completion through the update strobe.
module rr_arbiter2
  import memory_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       granted,
  output logic       grant_valid,
  output logic       grant
);

  logic last_grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= PORT_ICACHE;
    end else if (update) begin
      last_grant_q <= granted;
    end
  end

  always_comb begin
    grant_valid = |req;
    grant       = rr_pick(req, last_grant_q);
  end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises whole-line icache/dcache requests onto the single memory port and
// returns a one-cycle ready pulse (plus read data) to the port that was served.
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE    = 12,
  parameter int unsigned CACHE_LINE_SIZE = 128
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic                       icache_req,
  input  logic                       icache_op,
  input  logic [ADDRESS_SIZE-1:0]    icache_address,
  input  logic [CACHE_LINE_SIZE-1:0] icache_data_in,
  output logic [CACHE_LINE_SIZE-1:0] icache_data_out,
  output logic                       icache_ready,

  input  logic                       dcache_req,
  input  logic                       dcache_op,
  input  logic [ADDRESS_SIZE-1:0]    dcache_address,
  input  logic [CACHE_LINE_SIZE-1:0] dcache_data_in,
  output logic [CACHE_LINE_SIZE-1:0] dcache_data_out,
  output logic                       dcache_ready,

  output logic                       mem_enable,
  output logic                       mem_op,
  output logic [ADDRESS_SIZE-1:0]    mem_address,
  output logic [CACHE_LINE_SIZE-1:0] mem_data_in,
  output logic                       mem_op_done,
  input  logic [CACHE_LINE_SIZE-1:0] mem_data_out,
  input  logic                       mem_data_ready
);

  state_e state_q, state_d;

  logic                       grant_q;
  logic                       op_q;
  logic [ADDRESS_SIZE-1:0]    address_q;
  logic [CACHE_LINE_SIZE-1:0] data_in_q;
  logic [CACHE_LINE_SIZE-1:0] icache_data_out_q;
  logic [CACHE_LINE_SIZE-1:0] dcache_data_out_q;

  logic arb_valid;
  logic arb_grant;
  logic latch_en;
  logic capture_en;
  logic update_grant;

  rr_arbiter2 u_rr_arbiter2 (
    .clk         (clk),
    .reset       (reset),
    .req         ({dcache_req, icache_req}),
    .update      (update_grant),
    .granted     (grant_q),
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

  always_comb begin
    state_d      = state_q;
    latch_en     = 1'b0;
    capture_en   = 1'b0;
    update_grant = 1'b0;
    case (state_q)
      StFlush: state_d = StIdle;
      StIdle: begin
        if (arb_valid) begin
          latch_en = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (mem_data_ready) begin
          capture_en = 1'b1;
          state_d    = StDone;
        end
      end
      StDone: begin
        update_grant = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StFlush;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFlush;
    end else begin
      state_q <= state_d;
    end
  end

  // Request inputs are captured once at grant so the memory sees a stable command.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q   <= PORT_ICACHE;
      op_q      <= OP_READ;
      address_q <= '0;
      data_in_q <= '0;
    end else if (latch_en) begin
      grant_q <= arb_grant;
      if (arb_grant == PORT_DCACHE) begin
        op_q      <= dcache_op;
        address_q <= dcache_address;
        data_in_q <= dcache_data_in;
      end else begin
        op_q      <= icache_op;
        address_q <= icache_address;
        data_in_q <= icache_data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      icache_data_out_q <= '0;
      dcache_data_out_q <= '0;
    end else if (capture_en && (op_q == OP_READ)) begin
      if (grant_q == PORT_DCACHE) begin
        dcache_data_out_q <= mem_data_out;
      end else begin
        icache_data_out_q <= mem_data_out;
      end
    end
  end

  // Enable drops in the cycle data_ready rises so the memory never re-arms.
  always_comb begin
    mem_enable      = (state_q == StIssue) && !mem_data_ready;
    mem_op_done     = (state_q == StFlush) || (state_q == StDone);
    mem_op          = op_q;
    mem_address     = address_q;
    mem_data_in     = data_in_q;
    icache_ready    = (state_q == StDone) && (grant_q == PORT_ICACHE);
    dcache_ready    = (state_q == StDone) && (grant_q == PORT_DCACHE);
    icache_data_out = icache_data_out_q;
    dcache_data_out = dcache_data_out_q;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: behavioural memory with a fixed op delay, a
// transaction-level timing model, a per-cycle compare and directed scenarios.
module tb_memory_arbiter;
  import memory_pkg::*;

  localparam int AW = 12;
  localparam int LW = 128;
  localparam int D  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic          icache_req = 1'b0, icache_op = 1'b0;
  logic [AW-1:0] icache_address = '0;
  logic [LW-1:0] icache_data_in = '0;
  logic [LW-1:0] icache_data_out;
  logic          icache_ready;
  logic          dcache_req = 1'b0, dcache_op = 1'b0;
  logic [AW-1:0] dcache_address = '0;
  logic [LW-1:0] dcache_data_in = '0;
  logic [LW-1:0] dcache_data_out;
  logic          dcache_ready;

  logic          mem_enable, mem_op, mem_op_done;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_data_in;
  logic [LW-1:0] mem_data_out = '0;
  logic          mem_data_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  memory_arbiter #(
    .ADDRESS_SIZE    (AW),
    .CACHE_LINE_SIZE (LW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .icache_req      (icache_req),
    .icache_op       (icache_op),
    .icache_address  (icache_address),
    .icache_data_in  (icache_data_in),
    .icache_data_out (icache_data_out),
    .icache_ready    (icache_ready),
    .dcache_req      (dcache_req),
    .dcache_op       (dcache_op),
    .dcache_address  (dcache_address),
    .dcache_data_in  (dcache_data_in),
    .dcache_data_out (dcache_data_out),
    .dcache_ready    (dcache_ready),
    .mem_enable      (mem_enable),
    .mem_op          (mem_op),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .mem_op_done     (mem_op_done),
    .mem_data_out    (mem_data_out),
    .mem_data_ready  (mem_data_ready)
  );

  function automatic logic [LW-1:0] line_init(input logic [7:0] idx);
    return {8{idx, ~idx}};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // Memory: starts on enable, completes D cycles later, op_done clears/aborts.
  logic [LW-1:0] mem_arr [256];
  bit            mem_wr  [256];
  bit            m_busy = 1'b0;
  int            m_cnt  = 0;

  always @(posedge clk) begin
    if (mem_op_done) begin
      m_busy         <= 1'b0;
      mem_data_ready <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == D - 1) begin
        m_busy         <= 1'b0;
        mem_data_ready <= 1'b1;
        if (mem_op == OP_WRITE) begin
          mem_arr[mem_address[11:4]] <= mem_data_in;
          mem_wr[mem_address[11:4]]  <= 1'b1;
        end else begin
          mem_data_out <= mem_wr[mem_address[11:4]] ? mem_arr[mem_address[11:4]]
                                                    : line_init(mem_address[11:4]);
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (mem_enable && !mem_data_ready) begin
      m_busy <= 1'b1;
      m_cnt  <= 1;
    end
  end

  // Transaction-level model: a grant at edge N gives enable on N..N+D-1,
  // ready at edge N+D+1, and the next grant no earlier than edge N+D+3.
  int            cyc = 0;
  bit            last_rst = 1'b1;
  bit            busy_m = 1'b0, port_m = 1'b0, op_m = 1'b0, last_m = 1'b0;
  int            t_grant = 0, t_ready = 0, next_free = 0;
  logic [AW-1:0] addr_m = '0;
  logic [LW-1:0] din_m = '0, rd_m = '0;
  logic [LW-1:0] exp_out [2];
  logic [LW-1:0] shadow [256];

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = line_init(8'(i));
    exp_out[0] = '0;
    exp_out[1] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      last_rst = reset;
      if (reset) begin
        busy_m     = 1'b0;
        last_m     = PORT_ICACHE;
        op_m       = OP_READ;
        addr_m     = '0;
        din_m      = '0;
        exp_out[0] = '0;
        exp_out[1] = '0;
        next_free  = cyc + 2;
      end else begin
        if (busy_m && cyc == t_ready && op_m == OP_READ) exp_out[port_m] = rd_m;
        if (busy_m && cyc > t_ready) busy_m = 1'b0;
        if (!busy_m && cyc >= next_free && (icache_req || dcache_req)) begin
          port_m = (icache_req && dcache_req) ? ~last_m : dcache_req;
          last_m = port_m;
          op_m   = port_m ? dcache_op : icache_op;
          addr_m = port_m ? dcache_address : icache_address;
          din_m  = port_m ? dcache_data_in : icache_data_in;
          if (op_m == OP_WRITE) shadow[addr_m[11:4]] = din_m;
          else rd_m = shadow[addr_m[11:4]];
          t_grant   = cyc;
          t_ready   = cyc + D + 1;
          next_free = cyc + D + 3;
          busy_m    = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare against the model plus bus-protocol invariants.
  bit            prev_en = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic          prev_op = 1'b0;
  logic [LW-1:0] prev_din = '0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      bit exp_en, exp_done;
      exp_en   = busy_m && (cyc - t_grant) < D;
      exp_done = busy_m && (cyc == t_ready);
      check("icache_ready", icache_ready, exp_done && port_m == PORT_ICACHE);
      check("dcache_ready", dcache_ready, exp_done && port_m == PORT_DCACHE);
      check("mem_enable", mem_enable, exp_en);
      check("mem_op_done", mem_op_done, last_rst || exp_done);
      check("mem_address", mem_address, addr_m);
      check("mem_op", mem_op, op_m);
      check("mem_data_in", mem_data_in, din_m);
      check("icache_data_out", icache_data_out, exp_out[0]);
      check("dcache_data_out", dcache_data_out, exp_out[1]);
      check("enable_with_data_ready", mem_enable && mem_data_ready, 1'b0);
      if (mem_enable && prev_en) begin
        check("addr_stable", mem_address, prev_addr);
        check("op_stable", mem_op, prev_op);
        check("data_in_stable", mem_data_in, prev_din);
      end
      prev_en   = mem_enable;
      prev_addr = mem_address;
      prev_op   = mem_op;
      prev_din  = mem_data_in;
    end
  end

  int ipulses = 0, dpulses = 0;
  bit order_q [$];

  initial forever begin
    @(negedge clk);
    if (icache_ready === 1'b1) begin ipulses++; order_q.push_back(PORT_ICACHE); end
    if (dcache_ready === 1'b1) begin dpulses++; order_q.push_back(PORT_DCACHE); end
  end

  task automatic set_port(input bit p, input bit req, input bit op, input logic [AW-1:0] addr,
                          input logic [LW-1:0] data);
    if (p) begin
      dcache_req = req; dcache_op = op; dcache_address = addr; dcache_data_in = data;
    end else begin
      icache_req = req; icache_op = op; icache_address = addr; icache_data_in = data;
    end
  endtask

  // Holds req until n ready pulses; lat is edges from first request sample to first ready.
  task automatic port_txns(input bit p, input int n, input bit op, input logic [AW-1:0] addr,
                           input logic [LW-1:0] data, output int lat);
    int waited = 0;
    int got = 0;
    lat = -1;
    set_port(p, 1'b1, op, addr, data);
    while (got < n) begin
      @(negedge clk);
      waited++;
      if ((p ? dcache_ready : icache_ready) === 1'b1) begin
        got++;
        if (got == 1) lat = waited - 1;
        waited = 0;
        @(posedge clk); #1;
        if (got == n) set_port(p, 1'b0, op, addr, data);
      end else if (waited > 40) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout port %0d: got %0d ready pulses, expected %0d", p, got, n);
        set_port(p, 1'b0, op, addr, data);
        @(posedge clk); #1;
        return;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Icache read abandoned by a reset sampled k edges after its grant.
  task automatic abort_test(input int k);
    int ip0;
    ip0 = ipulses;
    @(posedge clk); #1;
    set_port(PORT_ICACHE, 1'b1, OP_READ, 12'h300, '0);
    @(posedge clk); #1;
    icache_req = 1'b0;
    repeat (k - 1) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_ready", ipulses - ip0, 0);
  endtask

  initial begin
    int lat_a, lat_b;
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_reset();
    @(negedge clk);
    check("flush_pulse", mem_op_done, 1'b1);
    @(negedge clk);
    check("flush_end", mem_op_done, 1'b0);
    repeat (4) @(negedge clk);
    check("idle_enable", mem_enable, 1'b0);
    @(posedge clk); #1;

    // Write then read back one dcache line.
    port_txns(PORT_DCACHE, 1, OP_WRITE, 12'h040, {16{8'hA5}}, lat_a);
    check("write_latency", lat_a, 5);
    port_txns(PORT_DCACHE, 1, OP_READ, 12'h040, '0, lat_b);
    check("read_latency", lat_b, 5);
    check("dcache_readback", dcache_data_out, {16{8'hA5}});
    check("icache_untouched", icache_data_out, '0);
    check("dcache_pulses", dpulses, 2);
    check("icache_pulses", ipulses, 0);

    // Tie straight after reset: dcache first.
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    order_q.delete();
    fork
      port_txns(PORT_ICACHE, 1, OP_READ, 12'h100, '0, lat_a);
      port_txns(PORT_DCACHE, 1, OP_READ, 12'h200, '0, lat_b);
    join
    check("tie_count", order_q.size(), 2);
    if (order_q.size() == 2) begin
      check("tie_first", order_q[0], PORT_DCACHE);
      check("tie_second", order_q[1], PORT_ICACHE);
    end
    check("tie_d_latency", lat_b, 5);
    check("tie_i_latency", lat_a, 11);
    check("tie_i_data", icache_data_out, line_init(8'h10));
    check("tie_d_data", dcache_data_out, line_init(8'h20));

    // Both held for two transactions each: D, I, D, I.
    @(posedge clk); #1;
    order_q.delete();
    fork
      port_txns(PORT_ICACHE, 2, OP_READ, 12'h110, '0, lat_a);
      port_txns(PORT_DCACHE, 2, OP_READ, 12'h220, '0, lat_b);
    join
    check("alt_count", order_q.size(), 4);
    if (order_q.size() == 4) begin
      check("alt_0", order_q[0], PORT_DCACHE);
      check("alt_1", order_q[1], PORT_ICACHE);
      check("alt_2", order_q[2], PORT_DCACHE);
      check("alt_3", order_q[3], PORT_ICACHE);
    end

    // Reset in mid-transaction, before and after the memory raises data_ready.
    abort_test(2);
    abort_test(3);
    check("abort_data_cleared", icache_data_out, '0);
    port_txns(PORT_ICACHE, 1, OP_READ, 12'h050, '0, lat_a);
    check("post_abort_latency", lat_a, 5);
    check("post_abort_data", icache_data_out, line_init(8'h05));

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached after %0d checks, expected completion", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
